// File: rtl/dual_ram_bytemask.sv
// Simple dual-port RAM with per-lane write mask, write-first forwarding and a bulk-clear sequencer.
// Latency: read_data/read_valid READ_LAT (1 or 2) cycles after an accepted read; writes land at the next posedge.
// Backpressure: none on the ports; while busy is high, write_en/read_en/clear are ignored.
module dual_ram_bytemask #(
    parameter int              SIZE      = 32,
    parameter int              LANE_W    = 8,
    parameter int              DEPTH     = 320,
    parameter int              READ_LAT  = 1,
    parameter logic [SIZE-1:0] CLEAR_VAL = '0,
    localparam int             LANES     = SIZE / LANE_W,
    localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    waddr,
    input  logic [SIZE-1:0]  write_data,
    input  logic [LANES-1:0] write_mask,
    input  logic             write_en,
    input  logic [AW-1:0]    raddr,
    input  logic             read_en,
    output logic [SIZE-1:0]  read_data,
    output logic             read_valid,
    input  logic             clear,
    output logic             busy
);

    // Bad parameter combinations stop elaboration rather than silently misbehaving.
    if ((SIZE % LANE_W) != 0) begin : g_bad_lane
        $error("SIZE must be a multiple of LANE_W");
    end
    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
        $error("READ_LAT must be 1 or 2");
    end

    // One bit wider than an address so DEPTH itself is representable for range checks.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    clr_state_t        state;
    logic [AW-1:0]     clr_cnt;

    logic [SIZE-1:0]   mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_acc;
    logic              rd_acc;
    logic              collide;
    logic [SIZE-1:0]   rd_word;
    logic [SIZE-1:0]   rd_fwd;

    logic              s1_vld;
    logic [SIZE-1:0]   s1_dat;

    // Accept logic: busy blocks both ports; an out-of-range write is simply dropped.
    assign wr_in_range = ({1'b0, waddr} < DEPTH_W);
    assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
    assign wr_acc      = write_en && !busy && wr_in_range;
    assign rd_acc      = read_en && !busy;
    assign collide     = wr_acc && rd_acc && (waddr == raddr);

    // Out-of-range reads still return a (zero) result so the requester sees its valid pulse.
    assign rd_word = rd_in_range ? mem[raddr] : '0;

    // Write-first per lane: lanes being written this cycle bypass the array, the rest read old contents.
    always_comb begin
        rd_fwd = rd_word;
        if (collide) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_mask[i]) begin
                    rd_fwd[i*LANE_W +: LANE_W] = write_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Array update: the clear sweep owns the array while busy, otherwise masked user writes.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= CLEAR_VAL;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_mask[i]) begin
                    mem[waddr][i*LANE_W +: LANE_W] <= write_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Clear sequencer: sweeps entries 0..DEPTH-1 once, busy mirrors the CLEAR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    clr_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: reads already in flight keep draining even after busy rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_dat     <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat <= rd_fwd;
            end
            if (READ_LAT == 2) begin
                read_valid <= s1_vld;
                if (s1_vld) begin
                    read_data <= s1_dat;
                end
            end else begin
                read_valid <= rd_acc;
                if (rd_acc) begin
                    read_data <= rd_fwd;
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_ram_bytemask.sv
// Randomized and directed bench for dual_ram_bytemask against an array-based reference model.
// Latency: expected results are queued with their due cycle and compared on arrival.
// Backpressure: busy is predicted by the model and compared every cycle.
module tb_dual_ram_bytemask;

    localparam int              SIZE      = 32;
    localparam int              LANE_W    = 8;
    localparam int              LANES     = SIZE / LANE_W;
    localparam int              DEPTH     = 320;
    localparam int              READ_LAT  = 1;
    localparam int              AW        = $clog2(DEPTH);
    localparam logic [SIZE-1:0] CLEAR_VAL = '0;
    localparam logic [SIZE-1:0] FILL      = 32'h5A5A5A5A;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    waddr;
    logic [SIZE-1:0]  write_data;
    logic [LANES-1:0] write_mask;
    logic             write_en;
    logic [AW-1:0]    raddr;
    logic             read_en;
    logic [SIZE-1:0]  read_data;
    logic             read_valid;
    logic             clear;
    logic             busy;

    dual_ram_bytemask #(
        .SIZE      (SIZE),
        .LANE_W    (LANE_W),
        .DEPTH     (DEPTH),
        .READ_LAT  (READ_LAT),
        .CLEAR_VAL (CLEAR_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .waddr      (waddr),
        .write_data (write_data),
        .write_mask (write_mask),
        .write_en   (write_en),
        .raddr      (raddr),
        .read_en    (read_en),
        .read_data  (read_data),
        .read_valid (read_valid),
        .clear      (clear),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [SIZE-1:0] dat;
    } rd_t;

    logic [SIZE-1:0] mdl [DEPTH];
    rd_t             rq [$];
    int              clr_left;
    int              cyc;
    logic [SIZE-1:0] exp_rdata;
    int              n_chk;
    int              n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle();
        write_en   = 1'b0;
        read_en    = 1'b0;
        clear      = 1'b0;
        write_mask = '0;
        write_data = '0;
        waddr      = '0;
        raddr      = '0;
    endtask

    // Advance one clock: update the model from the current inputs, then check the DUT after the edge.
    task automatic cycle();
        logic            busy_m;
        logic [SIZE-1:0] rv;
        rd_t             e;
        busy_m = (clr_left > 0);
        if (read_en && !busy_m) begin
            if (int'(raddr) < DEPTH) begin
                rv = mdl[raddr];
                if (write_en && waddr == raddr) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (write_mask[i]) rv[i*LANE_W +: LANE_W] = write_data[i*LANE_W +: LANE_W];
                    end
                end
            end else begin
                rv = '0;
            end
            rq.push_back('{cyc + READ_LAT, rv});
        end
        if (busy_m) begin
            mdl[DEPTH - clr_left] = CLEAR_VAL;
            clr_left--;
        end else begin
            if (clear) clr_left = DEPTH;
            if (write_en && int'(waddr) < DEPTH) begin
                for (int i = 0; i < LANES; i++) begin
                    if (write_mask[i]) mdl[waddr][i*LANE_W +: LANE_W] = write_data[i*LANE_W +: LANE_W];
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("busy", busy, clr_left > 0);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            chk("read_valid", read_valid, 1'b1);
            chk("read_data", read_data, e.dat);
            exp_rdata = e.dat;
        end else begin
            chk("read_valid_idle", read_valid, 1'b0);
            chk("read_data_hold", read_data, exp_rdata);
        end
    endtask

    task automatic fill_all(input logic [SIZE-1:0] val);
        for (int a = 0; a < DEPTH; a++) begin
            write_en = 1'b1; waddr = AW'(a); write_data = val; write_mask = '1;
            cycle();
        end
        idle();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            read_en = 1'b1; raddr = AW'(a);
            cycle();
        end
        idle();
        repeat (READ_LAT) cycle();
    endtask

    // Single read with a fixed expected value, checked exactly READ_LAT cycles later.
    task automatic read_expect(input int a, input logic [SIZE-1:0] exp, input string tag);
        read_en = 1'b1; raddr = AW'(a);
        cycle();
        idle();
        repeat (READ_LAT - 1) cycle();
        chk(tag, read_data, exp);
        chk({tag, "_vld"}, read_valid, 1'b1);
    endtask

    task automatic model_reset();
        clr_left  = 0;
        rq.delete();
        exp_rdata = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        n_chk = 0; n_pass = 0; cyc = 0;
        model_reset();
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst_read_data", read_data, '0);
        chk("rst_read_valid", read_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        fill_all(FILL);

        // Masked write: lanes 0 and 2 updated on top of a full write.
        write_en = 1'b1; waddr = AW'(5); write_data = 32'hAABBCCDD; write_mask = 4'b1111;
        cycle();
        write_data = 32'h11223344; write_mask = 4'b0101;
        cycle();
        idle();
        read_expect(5, 32'hAA22CC44, "masked_write");

        // Collision: write-first on masked lanes only.
        write_en = 1'b1; waddr = AW'(7); write_data = '0; write_mask = '1;
        cycle();
        write_data = 32'hFFFFFFFF; write_mask = 4'b0011; raddr = AW'(7); read_en = 1'b1;
        cycle();
        idle();
        repeat (READ_LAT - 1) cycle();
        chk("collision", read_data, 32'h0000FFFF);

        // Mask of zero is a no-op.
        write_en = 1'b1; waddr = AW'(7); write_data = 32'h12345678; write_mask = '0;
        cycle();
        idle();
        read_expect(7, 32'h0000FFFF, "mask_zero");

        // Streaming: back-to-back reads, one valid per cycle.
        for (int a = 0; a < 10; a++) begin
            write_en = 1'b1; waddr = AW'(a); write_data = SIZE'(a); write_mask = '1;
            cycle();
        end
        idle();
        for (int a = 0; a < 10; a++) begin
            read_en = 1'b1; raddr = AW'(a);
            cycle();
        end
        idle();
        repeat (READ_LAT) cycle();

        // Random traffic, occasional out-of-range addresses and clear pulses.
        for (int k = 0; k < 1500; k++) begin
            write_en   = ($urandom_range(0, 1) == 1);
            read_en    = ($urandom_range(0, 1) == 1);
            waddr      = AW'($urandom_range(0, 359));
            raddr      = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 359));
            write_data = $urandom;
            write_mask = LANES'($urandom);
            clear      = ($urandom_range(0, 499) == 0);
            cycle();
        end
        idle();
        while (clr_left > 0) cycle();
        repeat (READ_LAT) cycle();

        // Full clear: busy length, reads ignored while busy, second clear ignored.
        fill_all(FILL);
        clear = 1'b1; read_en = 1'b1; raddr = AW'(3);
        cycle();
        idle();
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 1000) begin
            n_busy++;
            read_en = 1'b1; raddr = AW'($urandom_range(0, DEPTH - 1));
            clear   = (n_busy == 150);
            cycle();
        end
        idle();
        chk("busy_len", n_busy, DEPTH);
        read_all();
        read_expect(0, CLEAR_VAL, "cleared_first");
        read_expect(DEPTH - 1, CLEAR_VAL, "cleared_last");

        // Reset part-way through a clear.
        fill_all(FILL);
        clear = 1'b1;
        cycle();
        idle();
        repeat (100) cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_read_valid", read_valid, 1'b0);
        chk("midrst_read_data", read_data, '0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        read_expect(99, CLEAR_VAL, "midrst_entry99");
        read_expect(100, FILL, "midrst_entry100");
        read_all();

        // Out-of-range write dropped, out-of-range read returns zero with valid.
        write_en = 1'b1; waddr = AW'(400); write_data = 32'hDEADBEEF; write_mask = '1;
        cycle();
        idle();
        read_expect(400, '0, "oob_read");
        read_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dual_ram_bytemask.md
Name: dual_ram_bytemask

Overview:
Single-clock simple dual-port RAM, successor to the team's basic write-port/read-port RAM. Adds per-lane write masking, a configurable read latency with a valid strobe, and write-first collision forwarding. A hardware bulk-clear sequencer wipes the whole array, for example to reset column/depth buffers between raycaster frames. Sits between the column renderer (writer) and the scan-out/compositor stage (reader).

Parameters:
SIZE, 32, entry width in bits; must be a multiple of LANE_W.
LANE_W, 8, bits per write-mask lane; LANES = SIZE/LANE_W.
DEPTH, 320, number of entries; need not be a power of two; AW = $clog2(DEPTH).
READ_LAT, 1, read latency in cycles; legal values are 1 or 2.
CLEAR_VAL, 0, SIZE-bit value written to every entry by the clear sequence.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
waddr  in  AW  write address.
write_data  in  SIZE  write data.
write_mask  in  LANES  per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W].
write_en  in  1  write request.
raddr  in  AW  read address.
read_en  in  1  read request.
read_data  out  SIZE  read result (registered).
read_valid  out  1  one-cycle pulse when read_data carries a new result.
clear  in  1  start bulk clear (pulse).
busy  out  1  clear sequence in progress.

Behaviour:
- Reset (async assert, sync release):
  - read_data=0, read_valid=0, busy=0, FSM=IDLE, clear counter=0, read pipeline valids=0.
  - Memory array is not reset.
- Write (accepted when write_en=1 and busy=0):
  - At posedge, lanes with write_mask[i]=1 take write_data; other lanes keep their contents.
  - write_mask=0 is a no-op.
  - waddr>=DEPTH: write dropped.
- Read (accepted when read_en=1 and busy=0):
  - READ_LAT=1: read_data/read_valid update at the first posedge after acceptance.
  - READ_LAT=2: one extra register stage; result appears one posedge later.
  - read_valid is high for exactly one cycle per accepted read. Back-to-back reads give back-to-back valids, throughput 1 read/cycle.
  - Without an accepted read, read_data holds its last value and read_valid=0.
  - raddr>=DEPTH: returns all zeros, read_valid still pulses.
- Collision (same-cycle accepted write and read, waddr==raddr):
  - Write-first per lane: masked lanes return write_data, unmasked lanes return the prior contents.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clear=1 -> CLEAR, counter=0. busy rises at the next posedge.
  - A write/read accepted in the same cycle as clear completes normally; the clear later overwrites it.
  - CLEAR: each cycle writes CLEAR_VAL to entry[counter], then counter+1.
  - When counter==DEPTH-1 (that write done) -> IDLE. busy is high for exactly DEPTH cycles.
  - clear while busy is ignored (no restart, no queueing).
  - While busy, write_en and read_en are ignored (no write, no read_valid).
  - Reads accepted before busy rose still drain through the pipeline with correct pre-clear data.
- Reset during CLEAR: FSM->IDLE, busy=0 immediately. Entries already cleared stay CLEAR_VAL; the rest keep their old contents.
- Arithmetic: counter is AW bits and never exceeds DEPTH-1. No wrap: the sequence ends at DEPTH-1.

Test Plan:
- Reset then masked write: write addr 5 = 0xAABBCCDD mask 1111; write addr 5 = 0x11223344 mask 0101; read addr 5 -> read_data 0xAA22CC44, read_valid one pulse 1 cycle after read_en (READ_LAT=1), 2 cycles (READ_LAT=2).
- Collision: addr 7 holds 0x00000000; same cycle write 0xFFFFFFFF mask 0011 and read addr 7 -> 0x0000FFFF.
- Streaming: read addrs 0..9 on consecutive cycles after writing data=addr -> 10 consecutive valids with data 0..9, no gaps.
- Clear: DEPTH=320, fill all entries with 0x5A5A5A5A, pulse clear -> busy high exactly 320 cycles. read_en during busy yields no valid. Afterwards all 320 reads return CLEAR_VAL. A second clear pulse mid-sequence does not extend busy.
- Reset mid-clear: assert rst_n=0 after 100 busy cycles -> busy=0, read_valid=0, read_data=0 at once. Entries 0..99 read CLEAR_VAL, entries 100..319 read 0x5A5A5A5A.
- Out of range: DEPTH=320, write addr 400 then read addr 400 -> returns 0 with valid. Entries 0..319 unchanged.
